// File: rtl/logic_capture_axi_pkg.sv
// Shared AXI encodings and request-entry layout for the capture memory AXI bridge.
// Entry packing, MSB first: {write, first, wlast, addr, id, len, burst, wdata, wstrb}.
package logic_capture_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int LEN_W   = 8;
    localparam int BURST_W = 2;

    function automatic int entry_width(input int addr_w, input int id_w, input int data_w);
        return 3 + addr_w + id_w + LEN_W + BURST_W + data_w + data_w / 8;
    endfunction

    function automatic int off_wdata(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_burst(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int off_len(input int data_w);
        return off_burst(data_w) + BURST_W;
    endfunction

    function automatic int off_id(input int data_w);
        return off_len(data_w) + LEN_W;
    endfunction

    function automatic int off_addr(input int id_w, input int data_w);
        return off_id(data_w) + id_w;
    endfunction

    function automatic int off_wlast(input int addr_w, input int id_w, input int data_w);
        return off_addr(id_w, data_w) + addr_w;
    endfunction

    function automatic int off_first(input int addr_w, input int id_w, input int data_w);
        return off_wlast(addr_w, id_w, data_w) + 1;
    endfunction

    function automatic int off_write(input int addr_w, input int id_w, input int data_w);
        return off_wlast(addr_w, id_w, data_w) + 2;
    endfunction

endpackage

// File: rtl/logic_capture_fifo.sv
// Generic synchronous FIFO with registered count, full and empty flags.
module logic_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && !full_q;
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; only entries marked valid by the count are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/logic_capture_mem_axi_bridge.sv
// Capture memory request port to AXI4 master bridge: registered request FIFO,
// in-order issue of AW/W/AR from the FIFO head, per-direction outstanding limits.
module logic_capture_mem_axi_bridge
    import logic_capture_axi_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inport_valid_i,
    input  logic                inport_write_i,
    input  logic [ADDR_W-1:0]   inport_addr_i,
    input  logic [ID_W-1:0]     inport_id_i,
    input  logic [7:0]          inport_len_i,
    input  logic [1:0]          inport_burst_i,
    input  logic [DATA_W-1:0]   inport_wdata_i,
    input  logic [DATA_W/8-1:0] inport_wstrb_i,
    output logic                inport_accept_o,
    output logic                inport_bvalid_o,
    output logic [1:0]          inport_bresp_o,
    output logic [ID_W-1:0]     inport_bid_o,
    input  logic                inport_bready_i,
    output logic                inport_rvalid_o,
    output logic [DATA_W-1:0]   inport_rdata_o,
    output logic [1:0]          inport_rresp_o,
    output logic [ID_W-1:0]     inport_rid_o,
    output logic                inport_rlast_o,
    input  logic                inport_rready_i,
    output logic                outport_awvalid_o,
    input  logic                outport_awready_i,
    output logic [ADDR_W-1:0]   outport_awaddr_o,
    output logic [ID_W-1:0]     outport_awid_o,
    output logic [7:0]          outport_awlen_o,
    output logic [1:0]          outport_awburst_o,
    output logic                outport_wvalid_o,
    input  logic                outport_wready_i,
    output logic [DATA_W-1:0]   outport_wdata_o,
    output logic [DATA_W/8-1:0] outport_wstrb_o,
    output logic                outport_wlast_o,
    input  logic                outport_bvalid_i,
    output logic                outport_bready_o,
    input  logic [1:0]          outport_bresp_i,
    input  logic [ID_W-1:0]     outport_bid_i,
    output logic                outport_arvalid_o,
    input  logic                outport_arready_i,
    output logic [ADDR_W-1:0]   outport_araddr_o,
    output logic [ID_W-1:0]     outport_arid_o,
    output logic [7:0]          outport_arlen_o,
    output logic [1:0]          outport_arburst_o,
    input  logic                outport_rvalid_i,
    output logic                outport_rready_o,
    input  logic [DATA_W-1:0]   outport_rdata_i,
    input  logic [1:0]          outport_rresp_i,
    input  logic [ID_W-1:0]     outport_rid_i,
    input  logic                outport_rlast_i,
    output logic [3:0]          wr_outstanding_o,
    output logic [3:0]          rd_outstanding_o,
    output logic                idle_o
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int ENTRY_W = entry_width(ADDR_W, ID_W, DATA_W);
    localparam int O_WDATA = off_wdata(DATA_W);
    localparam int O_BURST = off_burst(DATA_W);
    localparam int O_LEN   = off_len(DATA_W);
    localparam int O_ID    = off_id(DATA_W);
    localparam int O_ADDR  = off_addr(ID_W, DATA_W);
    localparam int O_WLAST = off_wlast(ADDR_W, ID_W, DATA_W);
    localparam int O_FIRST = off_first(ADDR_W, ID_W, DATA_W);
    localparam int O_WRITE = off_write(ADDR_W, ID_W, DATA_W);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [8:0]         beat_cnt_q, beat_cnt_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [3:0]         wr_out_q, wr_out_d;
    logic [3:0]         rd_out_q, rd_out_d;
    logic [8:0]         remaining;
    logic               push, pop, fifo_full, fifo_empty;
    logic               entry_first, entry_wlast;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               aw_now, w_now;
    logic               aw_hs, ar_hs, b_hs, r_last_hs;

    // Beat counter holds the beats still owed by the current write burst; zero means the next write beat opens a burst.
    always_comb begin
        push        = inport_valid_i && inport_accept_o;
        remaining   = (beat_cnt_q == '0) ? {1'b0, inport_len_i} : beat_cnt_q - 9'd1;
        entry_first = !inport_write_i || (beat_cnt_q == '0);
        entry_wlast = !inport_write_i || (remaining == '0);
        beat_cnt_d  = beat_cnt_q;
        if (push && inport_write_i) begin
            beat_cnt_d = remaining;
        end
        push_entry = {inport_write_i, entry_first, entry_wlast, inport_addr_i, inport_id_i,
                      inport_len_i, inport_burst_i, inport_wdata_i, inport_wstrb_i};
    end

    logic_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A first write beat owns both AW and W; it leaves the FIFO only once both have handshaked.
    always_comb begin
        outport_awvalid_o = 1'b0;
        outport_wvalid_o  = 1'b0;
        outport_arvalid_o = 1'b0;
        pop               = 1'b0;
        aw_now            = aw_done_q;
        w_now             = w_done_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        if (!fifo_empty) begin
            if (head_entry[O_WRITE]) begin
                if (head_entry[O_FIRST]) begin
                    outport_awvalid_o = !aw_done_q && (wr_out_q != MAX_OUT);
                    outport_wvalid_o  = !w_done_q;
                    aw_now    = aw_done_q || (outport_awvalid_o && outport_awready_i);
                    w_now     = w_done_q || (outport_wvalid_o && outport_wready_i);
                    pop       = aw_now && w_now;
                    aw_done_d = aw_now && !pop;
                    w_done_d  = w_now && !pop;
                end else begin
                    outport_wvalid_o = 1'b1;
                    pop              = outport_wready_i;
                end
            end else begin
                outport_arvalid_o = (rd_out_q != MAX_OUT);
                pop               = outport_arvalid_o && outport_arready_i;
            end
        end
    end

    always_comb begin
        aw_hs     = outport_awvalid_o && outport_awready_i;
        ar_hs     = outport_arvalid_o && outport_arready_i;
        b_hs      = outport_bvalid_i && inport_bready_i;
        r_last_hs = outport_rvalid_i && inport_rready_i && outport_rlast_i;
        wr_out_d  = wr_out_q;
        rd_out_d  = rd_out_q;
        if (aw_hs && !b_hs) begin
            wr_out_d = wr_out_q + 4'd1;
        end else if (!aw_hs && b_hs) begin
            wr_out_d = wr_out_q - 4'd1;
        end
        if (ar_hs && !r_last_hs) begin
            rd_out_d = rd_out_q + 4'd1;
        end else if (!ar_hs && r_last_hs) begin
            rd_out_d = rd_out_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_out_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            wr_out_q   <= wr_out_d;
            rd_out_q   <= rd_out_d;
        end
    end

    assign inport_accept_o   = rst_ni && !fifo_full;
    assign outport_awaddr_o  = head_entry[O_ADDR +: ADDR_W];
    assign outport_awid_o    = head_entry[O_ID +: ID_W];
    assign outport_awlen_o   = head_entry[O_LEN +: 8];
    assign outport_awburst_o = head_entry[O_BURST +: 2];
    assign outport_wdata_o   = head_entry[O_WDATA +: DATA_W];
    assign outport_wstrb_o   = head_entry[0 +: STRB_W];
    assign outport_wlast_o   = head_entry[O_WLAST];
    assign outport_araddr_o  = head_entry[O_ADDR +: ADDR_W];
    assign outport_arid_o    = head_entry[O_ID +: ID_W];
    assign outport_arlen_o   = head_entry[O_LEN +: 8];
    assign outport_arburst_o = head_entry[O_BURST +: 2];

    assign inport_bvalid_o   = outport_bvalid_i;
    assign inport_bresp_o    = outport_bresp_i;
    assign inport_bid_o      = outport_bid_i;
    assign outport_bready_o  = inport_bready_i;
    assign inport_rvalid_o   = outport_rvalid_i;
    assign inport_rdata_o    = outport_rdata_i;
    assign inport_rresp_o    = outport_rresp_i;
    assign inport_rid_o      = outport_rid_i;
    assign inport_rlast_o    = outport_rlast_i;
    assign outport_rready_o  = inport_rready_i;

    assign wr_outstanding_o  = wr_out_q;
    assign rd_outstanding_o  = rd_out_q;
    assign idle_o            = fifo_empty && (wr_out_q == '0) && (rd_out_q == '0);

endmodule
